// File: rtl/tx_lane_scheduler_pkg.sv
// Shared definitions for the PHY TX lane scheduler: widths, lane ids and a
// width helper used to size FIFO pointers and occupancy counters.
package phy_tx_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int LANE_W     = 1;

  localparam logic [LANE_W-1:0] LANE0 = 1'b0;
  localparam logic [LANE_W-1:0] LANE1 = 1'b1;

  // Pointer width for a FIFO of the given depth (depth is a power of two >= 2).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/tx_lane_scheduler_byte_fifo.sv
// Synchronous single-clock FIFO, one per requester. Pointers wrap naturally;
// the occupancy count is one bit wider so that full and empty are distinct.
// Push is ignored when full and pop is ignored when empty, so the caller may
// present raw requests.
module byte_fifo
  import phy_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       din,
  output logic [DATA_W-1:0]       dout,
  output logic [clog2(DEPTH):0]   level,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_push;
  logic              w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  assign full  = (r_count == (PTR_W + 1)'(DEPTH));
  assign empty = (r_count == '0);
  assign level = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // Storage array: written on an accepted push, never reset (the count gates reads).
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; reset flushes the FIFO regardless of traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tx_lane_scheduler.sv
// Schedules two buffered byte streams onto one TX byte path, one byte per
// cycle, either in fixed alternating slots or work-conserving round-robin.
//
// Handshakes: a byte moves on an interface at a rising edge where its valid
// and ready are both high. inN_ready depends only on the FIFO count register.
// Producers may raise valid without ready and must hold data until accepted.
// The output register is refilled whenever it is empty or out_ready is high;
// while out_valid && !out_ready it holds its byte and lane unchanged.
module tx_lane_scheduler
  import phy_tx_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          in0_data,
  input  logic                       in0_valid,
  output logic                       in0_ready,
  input  logic [DATA_W-1:0]          in1_data,
  input  logic                       in1_valid,
  output logic                       in1_ready,
  input  logic                       strict_alt,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  output logic                       out_lane,
  output logic [clog2(FIFO_DEPTH):0] level0,
  output logic [clog2(FIFO_DEPTH):0] level1
);

  logic [DATA_W-1:0] w_dout0;
  logic [DATA_W-1:0] w_dout1;
  logic              w_full0;
  logic              w_full1;
  logic [1:0]        w_empty;
  logic              w_push0;
  logic              w_push1;
  logic              w_pop0;
  logic              w_pop1;
  logic              w_adv;
  logic              w_grant;
  logic              w_lane;
  logic [DATA_W-1:0] w_head;

  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_lane;
  logic              r_slot;
  logic              r_last_grant;

  assign in0_ready = !w_full0;
  assign in1_ready = !w_full1;
  assign w_push0   = in0_valid && in0_ready;
  assign w_push1   = in1_valid && in1_ready;

  byte_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo0 (
    .clk   (clk),
    .reset (reset),
    .push  (w_push0),
    .pop   (w_pop0),
    .din   (in0_data),
    .dout  (w_dout0),
    .level (level0),
    .full  (w_full0),
    .empty (w_empty[0])
  );

  byte_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo1 (
    .clk   (clk),
    .reset (reset),
    .push  (w_push1),
    .pop   (w_pop1),
    .din   (in1_data),
    .dout  (w_dout1),
    .level (level1),
    .full  (w_full1),
    .empty (w_empty[1])
  );

  assign w_adv = !r_out_valid || out_ready;

  // Arbitration: pick the lane to serve this cycle, or none (bubble).
  always_comb begin
    w_grant = 1'b0;
    w_lane  = LANE0;
    if (strict_alt) begin
      w_lane  = r_slot;
      w_grant = !w_empty[r_slot];
    end else if (!w_empty[!r_last_grant]) begin
      w_lane  = !r_last_grant;
      w_grant = 1'b1;
    end else if (!w_empty[r_last_grant]) begin
      w_lane  = r_last_grant;
      w_grant = 1'b1;
    end
  end

  assign w_head = (w_lane == LANE1) ? w_dout1 : w_dout0;
  assign w_pop0 = w_adv && w_grant && (w_lane == LANE0);
  assign w_pop1 = w_adv && w_grant && (w_lane == LANE1);

  // Output register and arbiter state; everything holds while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_lane   <= LANE0;
      r_slot       <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_adv) begin
      r_slot      <= !r_slot;
      r_out_valid <= w_grant;
      if (w_grant) begin
        r_out_data   <= w_head;
        r_out_lane   <= w_lane;
        r_last_grant <= w_lane;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_lane  = r_out_lane;

endmodule

// File: tb/tb_tx_lane_scheduler.sv
// Directed bench for tx_lane_scheduler: a per-cycle vector table for reset,
// strict alternation and round-robin, then hand sequences for backpressure
// and reset in the middle of a stream.
module tb_tx_lane_scheduler;

  logic       clk;
  logic       reset;
  logic [7:0] in0_data;
  logic       in0_valid;
  logic       in0_ready;
  logic [7:0] in1_data;
  logic       in1_valid;
  logic       in1_ready;
  logic       strict_alt;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_lane;
  logic [2:0] level0;
  logic [2:0] level1;

  int n_tests;
  int n_fail;

  typedef struct {
    logic       rst;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       sa;
    logic       ordy;
    logic       e_valid;
    logic       chk_data;
    logic [7:0] e_data;
    logic       e_lane;
    logic [2:0] e_lvl0;
    logic [2:0] e_lvl1;
    logic       e_rdy0;
    logic       e_rdy1;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] exp_q[$];

  int p0;
  int p1;

  tx_lane_scheduler #(
    .DATA_W     (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in0_data   (in0_data),
    .in0_valid  (in0_valid),
    .in0_ready  (in0_ready),
    .in1_data   (in1_data),
    .in1_valid  (in1_valid),
    .in1_ready  (in1_ready),
    .strict_alt (strict_alt),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_lane   (out_lane),
    .level0     (level0),
    .level1     (level1)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    reset      = 1'b1;
    in0_data   = 8'h00;
    in0_valid  = 1'b0;
    in1_data   = 8'h00;
    in1_valid  = 1'b0;
    strict_alt = 1'b0;
    out_ready  = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic v0, input logic [7:0] d0,
                     input logic v1, input logic [7:0] d1, input logic sa, input logic ordy,
                     input logic ev, input logic cd, input logic [7:0] ed, input logic el,
                     input logic [2:0] l0, input logic [2:0] l1, input logic r0, input logic r1);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.sa = sa; v.ordy = ordy;
    v.e_valid = ev; v.chk_data = cd; v.e_data = ed; v.e_lane = el;
    v.e_lvl0 = l0; v.e_lvl1 = l1; v.e_rdy0 = r0; v.e_rdy1 = r1;
    vecs.push_back(v);
  endtask

  // Driver for the backpressure sequence: lane 0 offers C0.., lane 1 offers
  // D0..; a byte advances only once it was accepted at an edge.
  task automatic bp_cycle(input logic ordy, input logic push_en);
    logic acc0;
    logic acc1;
    out_ready  = ordy;
    strict_alt = 1'b0;
    in0_valid  = push_en;
    in1_valid  = push_en;
    in0_data   = 8'hC0 + 8'(p0);
    in1_data   = 8'hD0 + 8'(p1);
    acc0 = push_en && in0_ready;
    acc1 = push_en && in1_ready;
    @(posedge clk);
    #1;
    if (acc0) p0++;
    if (acc1) p1++;
  endtask

  task automatic idle_cycle(input logic ordy);
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    p0 = 0;
    p1 = 0;

    // Reset held two cycles while lane 0 offers a byte; then one byte, no bypass.
    add(1, 1, 8'h11, 0, 8'h00, 0, 1,  0, 1, 8'h00, 0,  0, 0, 1, 1);
    add(1, 1, 8'h11, 0, 8'h00, 0, 1,  0, 1, 8'h00, 0,  0, 0, 1, 1);
    add(0, 1, 8'h11, 0, 8'h00, 0, 1,  0, 0, 8'h00, 0,  1, 0, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 0, 1,  1, 1, 8'h11, 0,  0, 0, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 0, 1,  0, 0, 8'h00, 0,  0, 0, 1, 1);
    // Strict alternation with both lanes streaming (slot is 1 on entry).
    add(0, 1, 8'hA0, 1, 8'hB0, 1, 1,  0, 0, 8'h00, 0,  1, 1, 1, 1);
    add(0, 1, 8'hA1, 1, 8'hB1, 1, 1,  1, 1, 8'hA0, 0,  1, 2, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1, 1,  1, 1, 8'hB0, 1,  1, 1, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1, 1,  1, 1, 8'hA1, 0,  0, 1, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1, 1,  1, 1, 8'hB1, 1,  0, 0, 1, 1);
    // Strict alternation, only lane 1 active: lane 0 slots become bubbles.
    add(0, 0, 8'h00, 1, 8'h55, 1, 1,  0, 0, 8'h00, 0,  0, 1, 1, 1);
    add(0, 0, 8'h00, 1, 8'h55, 1, 1,  1, 1, 8'h55, 1,  0, 1, 1, 1);
    add(0, 0, 8'h00, 1, 8'h55, 1, 1,  0, 0, 8'h00, 0,  0, 2, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1, 1,  1, 1, 8'h55, 1,  0, 1, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1, 1,  0, 0, 8'h00, 0,  0, 1, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1, 1,  1, 1, 8'h55, 1,  0, 0, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1, 1,  0, 0, 8'h00, 0,  0, 0, 1, 1);
    // Round-robin, only lane 0 active: back-to-back grants.
    add(0, 1, 8'h01, 0, 8'h00, 0, 1,  0, 0, 8'h00, 0,  1, 0, 1, 1);
    add(0, 1, 8'h02, 0, 8'h00, 0, 1,  1, 1, 8'h01, 0,  1, 0, 1, 1);
    add(0, 1, 8'h03, 0, 8'h00, 0, 1,  1, 1, 8'h02, 0,  1, 0, 1, 1);
    add(0, 1, 8'h04, 0, 8'h00, 0, 1,  1, 1, 8'h03, 0,  1, 0, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 0, 1,  1, 1, 8'h04, 0,  0, 0, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 0, 1,  0, 0, 8'h00, 0,  0, 0, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      reset      = vecs[i].rst;
      in0_valid  = vecs[i].v0;
      in0_data   = vecs[i].d0;
      in1_valid  = vecs[i].v1;
      in1_data   = vecs[i].d1;
      strict_alt = vecs[i].sa;
      out_ready  = vecs[i].ordy;
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].e_data));
        check($sformatf("v%0d out_lane", i), 32'(out_lane), 32'(vecs[i].e_lane));
      end
      check($sformatf("v%0d level0", i), 32'(level0), 32'(vecs[i].e_lvl0));
      check($sformatf("v%0d level1", i), 32'(level1), 32'(vecs[i].e_lvl1));
      check($sformatf("v%0d in0_ready", i), 32'(in0_ready), 32'(vecs[i].e_rdy0));
      check($sformatf("v%0d in1_ready", i), 32'(in1_ready), 32'(vecs[i].e_rdy1));
    end

    // Backpressure: D0 is granted first (last grant was lane 0), then the
    // output stalls for six cycles while both FIFOs fill to the brim.
    bp_cycle(1'b0, 1'b1);
    check("bp first bubble", 32'(out_valid), 32'd0);
    bp_cycle(1'b0, 1'b1);
    check("bp grant valid", 32'(out_valid), 32'd1);
    check("bp grant data", 32'(out_data), 32'hD0);
    for (int c = 0; c < 6; c++) begin
      bp_cycle(1'b0, 1'b1);
      check($sformatf("bp stall%0d valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp stall%0d data", c), 32'(out_data), 32'hD0);
      check($sformatf("bp stall%0d lane", c), 32'(out_lane), 32'd1);
    end
    check("bp level0 full", 32'(level0), 32'd4);
    check("bp level1 full", 32'(level1), 32'd4);
    check("bp in0_ready low", 32'(in0_ready), 32'd0);
    check("bp in1_ready low", 32'(in1_ready), 32'd0);
    check("bp lane0 accepted", 32'(p0), 32'd4);
    check("bp lane1 accepted", 32'(p1), 32'd5);

    // Release: round-robin alternates starting with lane 0.
    exp_q = '{8'hC0, 8'hD1, 8'hC1, 8'hD2, 8'hC2, 8'hD3, 8'hC3, 8'hD4};
    for (int c = 0; c < 20; c++) begin
      bp_cycle(1'b1, 1'b0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("bp extra byte", 32'(out_data), 32'hFFFF);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check($sformatf("bp release data %0d", c), 32'(out_data), 32'(e));
          check($sformatf("bp release lane %0d", c), 32'(out_lane), 32'(e[7:4] == 4'hD));
        end
      end
    end
    check("bp bytes outstanding", exp_q.size(), 32'd0);
    check("bp drained level0", 32'(level0), 32'd0);
    check("bp drained level1", 32'(level1), 32'd0);

    // Reset mid-stream: fill lane 0 to three entries behind a stalled output.
    strict_alt = 1'b0;
    out_ready  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in0_valid = 1'b1;
      in0_data  = 8'hE0 + 8'(c);
      @(posedge clk);
      #1;
    end
    check("mid level0", 32'(level0), 32'd3);
    check("mid out_valid", 32'(out_valid), 32'd1);
    check("mid out_data", 32'(out_data), 32'hE0);
    in0_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst out_lane", 32'(out_lane), 32'd0);
    check("rst level0", 32'(level0), 32'd0);
    check("rst level1", 32'(level1), 32'd0);
    check("rst in0_ready", 32'(in0_ready), 32'd1);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      idle_cycle(1'b1);
      check($sformatf("post rst%0d out_valid", c), 32'(out_valid), 32'd0);
      check($sformatf("post rst%0d level0", c), 32'(level0), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
